// File: rtl/therm_dac_drv_if.sv
// Handshake bundle for therm_dac_drv: code input side, thermometer output side and DWA pointer.
interface therm_dac_drv_if;
  logic [3:0]  b;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ptr;

  modport master (
    output b, in_valid, out_ready,
    input  in_ready, Y, out_valid, ptr
  );

  modport slave (
    input  b, in_valid, out_ready,
    output in_ready, Y, out_valid, ptr
  );
endinterface

// File: rtl/therm_dac_drv.sv
// Binary-to-thermometer decoder for the 15-element unary feedback DAC, one registered output stage.
// Define THERM_DAC_DWA_EN to add the data-weighted-averaging rotator and its start pointer.
module therm_dac_drv (
  input  logic           clk,
  input  logic           rst,
  therm_dac_drv_if.slave bus
);
  logic [14:0] y_q;
  logic [14:0] y_next;
  logic        valid_q;
  logic        in_ready;
  logic        accept;

  assign in_ready      = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.Y         = y_q;
  assign bus.out_valid = valid_q;

`ifdef THERM_DAC_DWA_EN
  logic [3:0] ptr_q;
  logic [3:0] ptr_next;
  logic [4:0] ptr_sum;
  logic [4:0] dist;

  assign ptr_sum  = {1'b0, ptr_q} + {1'b0, bus.b};
  assign ptr_next = (ptr_sum >= 5'd15) ? 4'(ptr_sum - 5'd15) : ptr_sum[3:0];
  assign bus.ptr  = ptr_q;

  // Element i is lit when its descending distance from start index 14-ptr (mod 15) is below k.
  always_comb begin
    y_next = '0;
    dist   = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      dist = 5'd29 - {1'b0, ptr_q} - 5'(i);
      if (dist >= 5'd15) dist = dist - 5'd15;
      y_next[i] = (dist < {1'b0, bus.b});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_next;
    end
  end
`else
  assign bus.ptr = '0;

  always_comb begin
    y_next = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      y_next[i] = (5'(i) >= (5'd15 - {1'b0, bus.b}));
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      y_q     <= y_next;
      valid_q <= 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_therm_dac_drv.sv
// Self-checking bench for therm_dac_drv: directed plan cases plus randomized traffic against a behavioural model.
module tb_therm_dac_drv;
  logic clk = 1'b0;
  logic rst;

  therm_dac_drv_if bus();

  therm_dac_drv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  logic [14:0] m_y   = '0;
  bit          m_v   = 1'b0;
  int          m_ptr = 0;

  function automatic logic [14:0] ref_word(int k, int p);
    logic [14:0] w;
    w = '0;
`ifdef THERM_DAC_DWA_EN
    for (int j = 0; j < k; j++) w[(((14 - p - j) % 15) + 15) % 15] = 1'b1;
`else
    w = 15'(((1 << k) - 1) << (15 - k));
`endif
    return w;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: one output slot, word computed from the set of lit element positions.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_y   = '0;
      m_v   = 1'b0;
      m_ptr = 0;
    end else if (bus.in_valid && (!m_v || bus.out_ready)) begin
      m_y = ref_word(int'(bus.b), m_ptr);
`ifdef THERM_DAC_DWA_EN
      m_ptr = (m_ptr + int'(bus.b)) % 15;
`endif
      m_v = 1'b1;
    end else if (bus.out_ready) begin
      m_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("cyc_Y", 32'(bus.Y), 32'(m_y));
      check("cyc_out_valid", 32'(bus.out_valid), 32'(m_v));
      check("cyc_ptr", 32'(bus.ptr), 32'(m_ptr));
      check("cyc_in_ready", 32'(bus.in_ready), 32'(!m_v || bus.out_ready));
    end
  end

  initial begin
    bus.b         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;

`ifdef THERM_DAC_DWA_EN
    check("model_dwa_k7_p10", 32'(ref_word(7, 10)), 32'h601F);
    check("model_dwa_k10_p0", 32'(ref_word(10, 0)), 32'h7FE0);
`else
    check("model_k8", 32'(ref_word(8, 0)), 32'h7F80);
    check("model_k2", 32'(ref_word(2, 0)), 32'h6000);
`endif

    repeat (2) step();
    check("rst_Y", 32'(bus.Y), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_ptr", 32'(bus.ptr), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst    = 1'b1;
    chk_en = 1'b1;

    // Sweep every code with the sink always ready.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.b = 4'(k);
      step();
      check("sweep_out_valid", 32'(bus.out_valid), 32'h1);
      check("sweep_popcount", 32'($countones(bus.Y)), 32'(k));
`ifndef THERM_DAC_DWA_EN
      case (k)
        0:  check("sweep_k0", 32'(bus.Y), 32'h0000);
        1:  check("sweep_k1", 32'(bus.Y), 32'h4000);
        2:  check("sweep_k2", 32'(bus.Y), 32'h6000);
        8:  check("sweep_k8", 32'(bus.Y), 32'h7F80);
        15: check("sweep_k15", 32'(bus.Y), 32'h7FFF);
        default: ;
      endcase
`endif
    end

    // Backpressure: hold k=9 against a stalled sink.
    bus.b = 4'd5;
    step();
`ifndef THERM_DAC_DWA_EN
    check("bp_k5", 32'(bus.Y), 32'h7C00);
`endif
    bus.out_ready = 1'b0;
    bus.b         = 4'd9;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
`ifndef THERM_DAC_DWA_EN
      check("bp_hold_Y", 32'(bus.Y), 32'h7C00);
`endif
    end
    bus.out_ready = 1'b1;
    step();
`ifndef THERM_DAC_DWA_EN
    check("bp_k9", 32'(bus.Y), 32'h7FC0);
`endif

    // Simultaneous drain and accept.
    bus.b = 4'd3;
    step();
`ifndef THERM_DAC_DWA_EN
    check("b2b_k3", 32'(bus.Y), 32'h7000);
`endif
    check("b2b_valid0", 32'(bus.out_valid), 32'h1);
    bus.b = 4'd12;
    step();
`ifndef THERM_DAC_DWA_EN
    check("b2b_k12", 32'(bus.Y), 32'h7FF8);
`endif
    check("b2b_valid1", 32'(bus.out_valid), 32'h1);
    bus.b = 4'd0;
    step();
`ifndef THERM_DAC_DWA_EN
    check("b2b_k0", 32'(bus.Y), 32'h0000);
`endif
    check("b2b_valid2", 32'(bus.out_valid), 32'h1);

`ifdef THERM_DAC_DWA_EN
    // DWA wrap from a fresh reset.
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.b = 4'd10;
    step();
    check("dwa_k10_Y", 32'(bus.Y), 32'h7FE0);
    check("dwa_k10_ptr", 32'(bus.ptr), 32'd10);
    bus.b = 4'd7;
    step();
    check("dwa_k7_Y", 32'(bus.Y), 32'h601F);
    check("dwa_k7_ptr", 32'(bus.ptr), 32'd2);
    bus.b = 4'd15;
    step();
    check("dwa_k15_Y", 32'(bus.Y), 32'h7FFF);
    check("dwa_k15_ptr", 32'(bus.ptr), 32'd2);
`endif

    // Async reset while stalled on a full word.
    bus.b = 4'd15;
    step();
    check("ar_full", 32'(bus.Y), 32'h7FFF);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    #3;
    rst = 1'b0;
    #1;
    check("ar_Y", 32'(bus.Y), 32'h0);
    check("ar_out_valid", 32'(bus.out_valid), 32'h0);
    check("ar_ptr", 32'(bus.ptr), 32'h0);
    check("ar_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    rst = 1'b1;
    bus.b         = 4'd1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("ar_first_k1", 32'(bus.Y), 32'h4000);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 400; n++) begin
      bus.b         = 4'($urandom_range(15));
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      step();
    end

    bus.in_valid = 1'b0;
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
